// File: rtl/bram_operand_streamer_if.sv
// Bus bundle between the operand streamer, its BRAM port and the compute core.
// The master side is the streamer; the slave side is the BRAM plus the core.
interface bram_operand_streamer_if #(
  parameter int BLOCK_WIDTH = 17,
  parameter int BLK_W       = 4
);
  logic [31:0]            BRAM_dout_i;
  logic [31:0]            BRAM_din_o;
  logic [3:0]             BRAM_we_o;
  logic [31:0]            BRAM_addr_o;
  logic                   BRAM_en_o;
  logic [BLOCK_WIDTH-1:0] op_data_o;
  logic [1:0]             op_idx_o;
  logic [BLK_W-1:0]       op_blk_o;
  logic                   op_valid_o;
  logic                   op_ready_i;
  logic [BLOCK_WIDTH-1:0] res_data_i;
  logic                   res_valid_i;
  logic                   res_ready_o;

  modport master (
    input  BRAM_dout_i, op_ready_i, res_data_i, res_valid_i,
    output BRAM_din_o, BRAM_we_o, BRAM_addr_o, BRAM_en_o,
    output op_data_o, op_idx_o, op_blk_o, op_valid_o, res_ready_o
  );

  modport slave (
    output BRAM_dout_i, op_ready_i, res_data_i, res_valid_i,
    input  BRAM_din_o, BRAM_we_o, BRAM_addr_o, BRAM_en_o,
    input  op_data_o, op_idx_o, op_blk_o, op_valid_o, res_ready_o
  );
endinterface

// File: rtl/bram_operand_streamer.sv
// Streams N_OPERANDS operands block by block out of a BRAM to the core,
// then writes S result blocks coming back from the core into the BRAM.
module bram_operand_streamer #(
  parameter int          WIDTH        = 256,
  parameter int          BLOCK_WIDTH  = 17,
  parameter int          N_OPERANDS   = 3,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR    = 32'd0,
  parameter logic [31:0] RES_ADDR     = 32'd48,
  localparam int         S            = (WIDTH + 1) / BLOCK_WIDTH + 1,
  localparam int         BLK_W        = (S > 1) ? $clog2(S) : 1
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic start_i,
  output logic busy_o,
  output logic done_o,
  bram_operand_streamer_if.master bus
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, PRESENT, RES, DONE} state_t;

  localparam logic [BLK_W-1:0] LAST_BLK  = BLK_W'(S - 1);
  localparam logic [1:0]       LAST_OP   = 2'(N_OPERANDS - 1);
  localparam logic [1:0]       LAST_WAIT = 2'(READ_LATENCY - 1);

  state_t                 state;
  logic [1:0]             k;          // operand index
  logic [BLK_W-1:0]       j;          // block index within operand
  logic [BLK_W-1:0]       r;          // result block index
  logic [1:0]             wait_cnt;   // cycles spent in RD_WAIT
  logic [BLOCK_WIDTH-1:0] op_data;
  logic [31:0]            rd_word;
  logic [31:0]            wr_word;

  // Word addresses; 32-bit arithmetic wraps naturally.
  assign rd_word = BASE_ADDR + 32'(k) * 32'(S) + 32'(j);
  assign wr_word = RES_ADDR + 32'(r);

  // Main sequencer: read/present each block, then collect results.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state    <= IDLE;
      k        <= '0;
      j        <= '0;
      r        <= '0;
      wait_cnt <= '0;
      op_data  <= '0;
    end else begin
      case (state)
        IDLE:     if (start_i) state <= RD_ISSUE;
        RD_ISSUE: begin
          wait_cnt <= '0;
          state    <= RD_WAIT;
        end
        RD_WAIT: begin
          if (wait_cnt == LAST_WAIT) begin
            op_data <= bus.BRAM_dout_i[BLOCK_WIDTH-1:0];
            state   <= PRESENT;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        PRESENT: begin
          if (bus.op_ready_i) begin
            if (j == LAST_BLK && k == LAST_OP) begin
              state <= RES;
            end else begin
              if (j == LAST_BLK) begin
                j <= '0;
                k <= k + 2'd1;
              end else begin
                j <= j + BLK_W'(1);
              end
              state <= RD_ISSUE;
            end
          end
        end
        RES: begin
          if (bus.res_valid_i) begin
            r <= r + BLK_W'(1);
            if (r == LAST_BLK) state <= DONE;
          end
        end
        DONE: begin
          k     <= '0;
          j     <= '0;
          r     <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // BRAM port: read strobe in RD_ISSUE, same-cycle write per valid result.
  always_comb begin
    bus.BRAM_en_o   = 1'b0;
    bus.BRAM_we_o   = 4'h0;
    bus.BRAM_addr_o = 32'd0;
    bus.BRAM_din_o  = 32'd0;
    if (state == RD_ISSUE) begin
      bus.BRAM_en_o   = 1'b1;
      bus.BRAM_addr_o = rd_word << 2;
    end else if (state == RES && bus.res_valid_i) begin
      bus.BRAM_en_o   = 1'b1;
      bus.BRAM_we_o   = 4'hF;
      bus.BRAM_addr_o = wr_word << 2;
      bus.BRAM_din_o  = 32'(bus.res_data_i);
    end
  end

  assign bus.op_data_o   = op_data;
  assign bus.op_idx_o    = k;
  assign bus.op_blk_o    = j;
  assign bus.op_valid_o  = (state == PRESENT);
  assign bus.res_ready_o = (state == RES);
  assign busy_o          = (state != IDLE);
  assign done_o          = (state == DONE);

endmodule

// File: tb/tb_bram_operand_streamer.sv
// Directed bench: default-parameter streamer plus a READ_LATENCY=3 instance,
// each with a small BRAM model.
module tb_bram_operand_streamer;

  localparam int BW   = 17;
  localparam int BLKW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic start0, start1;
  logic busy0, done0, busy1, done1;
  logic mem_load;

  int checks = 0;
  int errors = 0;
  int done_cnt0 = 0;

  bram_operand_streamer_if #(.BLOCK_WIDTH(BW), .BLK_W(BLKW)) bus0 ();
  bram_operand_streamer_if #(.BLOCK_WIDTH(BW), .BLK_W(BLKW)) bus1 ();

  bram_operand_streamer u_dut0 (
    .clock_i(clk), .reset_i(rst_n), .start_i(start0),
    .busy_o(busy0), .done_o(done0), .bus(bus0)
  );

  bram_operand_streamer #(.READ_LATENCY(3)) u_dut1 (
    .clock_i(clk), .reset_i(rst_n), .start_i(start1),
    .busy_o(busy1), .done_o(done1), .bus(bus1)
  );

  always #5 clk = ~clk;

  // BRAM model, latency 1
  logic [31:0] mem0 [0:63];
  logic [31:0] p0;
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem0[i] <= (i < 48) ? 32'h1000 + 32'(i) : 32'd0;
    end else if (bus0.BRAM_en_o) begin
      if (bus0.BRAM_we_o == 4'hF) mem0[bus0.BRAM_addr_o[7:2]] <= bus0.BRAM_din_o;
      else                        p0 <= mem0[bus0.BRAM_addr_o[7:2]];
    end
  end
  assign bus0.BRAM_dout_i = p0;

  // BRAM model, latency 3; upper data bits set to exercise truncation
  logic [31:0] mem1 [0:63];
  logic [31:0] q0, q1, q2;
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem1[i] <= 32'hFFFE_0000 | (32'h1000 + 32'(i));
    end else if (bus1.BRAM_en_o) begin
      if (bus1.BRAM_we_o == 4'hF) mem1[bus1.BRAM_addr_o[7:2]] <= bus1.BRAM_din_o;
      else                        q0 <= mem1[bus1.BRAM_addr_o[7:2]];
    end
    q1 <= q0;
    q2 <= q1;
  end
  assign bus1.BRAM_dout_i = q2;

  // completion pulse counter
  always @(negedge clk) if (done0) done_cnt0 <= done_cnt0 + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_en"},    32'(bus0.BRAM_en_o),   32'd0);
    chk({tag, "_we"},    32'(bus0.BRAM_we_o),   32'd0);
    chk({tag, "_addr"},  bus0.BRAM_addr_o,      32'd0);
    chk({tag, "_din"},   bus0.BRAM_din_o,       32'd0);
    chk({tag, "_data"},  32'(bus0.op_data_o),   32'd0);
    chk({tag, "_idx"},   32'(bus0.op_idx_o),    32'd0);
    chk({tag, "_blk"},   32'(bus0.op_blk_o),    32'd0);
    chk({tag, "_valid"}, 32'(bus0.op_valid_o),  32'd0);
    chk({tag, "_rrdy"},  32'(bus0.res_ready_o), 32'd0);
    chk({tag, "_busy"},  32'(busy0),            32'd0);
    chk({tag, "_done"},  32'(done0),            32'd0);
  endtask

  // Caller raises start0 just before; this drops it on the first negedge.
  task automatic read_phase(input bit stall);
    int n = 0;
    int cyc = 0;
    int t_xfer = 0;
    int st = 0;
    bit seen = 1'b0;
    bus0.op_ready_i = 1'b1;
    while (n < 48 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start0 = 1'b0;
      if (bus0.BRAM_en_o) begin
        chk($sformatf("rd_addr%0d", n), bus0.BRAM_addr_o, 32'(n) << 2);
        chk($sformatf("rd_we%0d", n), 32'(bus0.BRAM_we_o), 32'd0);
      end
      if (bus0.op_valid_o) begin
        if (!seen) begin
          seen = 1'b1;
          chk($sformatf("gap%0d", n), 32'(cyc - t_xfer), 32'd3);
          chk($sformatf("data%0d", n), 32'(bus0.op_data_o), 32'h1000 + 32'(n));
          chk($sformatf("idx%0d", n), 32'(bus0.op_idx_o), 32'(n / 16));
          chk($sformatf("blk%0d", n), 32'(bus0.op_blk_o), 32'(n % 16));
        end
        if (stall && n == 7 && st < 5) begin
          bus0.op_ready_i  = 1'b0;
          bus0.res_valid_i = 1'b1;
          bus0.res_data_i  = 17'h0ABCD;
          start0 = (st == 2);
          st++;
          #1;
          chk($sformatf("stall_data%0d", st), 32'(bus0.op_data_o), 32'h1007);
          chk($sformatf("stall_blk%0d", st), 32'(bus0.op_blk_o), 32'd7);
          chk($sformatf("stall_en%0d", st), 32'(bus0.BRAM_en_o), 32'd0);
        end else begin
          bus0.op_ready_i  = 1'b1;
          bus0.res_valid_i = 1'b0;
          start0 = 1'b0;
          n++;
          seen = 1'b0;
          t_xfer = cyc;
        end
      end
    end
    chk("rd_count", 32'(n), 32'd48);
  endtask

  // Entered at the negedge of the final operand transfer.
  task automatic res_phase(input int nwr, input bit poke);
    @(negedge clk);
    chk("res_ready", 32'(bus0.res_ready_o), 32'd1);
    chk("res_opvalid", 32'(bus0.op_valid_o), 32'd0);
    for (int r = 0; r < nwr; r++) begin
      if (r % 2 == 1) begin
        bus0.res_valid_i = 1'b0;
        #1 chk($sformatf("res_gap_en%0d", r), 32'(bus0.BRAM_en_o), 32'd0);
        @(negedge clk);
      end
      bus0.res_valid_i = 1'b1;
      bus0.res_data_i  = 17'(32'h1FFFF - 32'(r));
      start0 = poke && (r == 3);
      #1;
      chk($sformatf("wr_en%0d", r), 32'(bus0.BRAM_en_o), 32'd1);
      chk($sformatf("wr_we%0d", r), 32'(bus0.BRAM_we_o), 32'hF);
      chk($sformatf("wr_addr%0d", r), bus0.BRAM_addr_o, 32'hC0 + 32'(4 * r));
      chk($sformatf("wr_din%0d", r), bus0.BRAM_din_o, 32'h1FFFF - 32'(r));
      chk($sformatf("wr_done%0d", r), 32'(done0), 32'd0);
      @(negedge clk);
      start0 = 1'b0;
    end
    bus0.res_valid_i = 1'b0;
    if (nwr == 16) begin
      #1;
      chk("done_hi", 32'(done0), 32'd1);
      chk("done_en", 32'(bus0.BRAM_en_o), 32'd0);
      @(negedge clk);
      chk("done_lo", 32'(done0), 32'd0);
      chk("idle_busy", 32'(busy0), 32'd0);
    end
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    mem_load = 1'b0;
    bus0.op_ready_i = 1'b0; bus0.res_valid_i = 1'b0; bus0.res_data_i = '0;
    bus1.op_ready_i = 1'b0; bus1.res_valid_i = 1'b0; bus1.res_data_i = '0;
    @(negedge clk); mem_load = 1'b1;
    @(negedge clk); mem_load = 1'b0;
    #1 chk_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 32'(busy0), 32'd0);

    // run 1: stall at block 7, stray starts, gapped results
    start0 = 1'b1;
    read_phase(1'b1);
    res_phase(16, 1'b1);
    for (int r = 0; r < 16; r++)
      chk($sformatf("mem_res%0d", r), mem0[48 + r], 32'h1FFFF - 32'(r));
    repeat (3) @(negedge clk);
    chk("no_restart", 32'(busy0), 32'd0);

    // run 2: reset after 5 result writes, then a clean run
    start0 = 1'b1;
    read_phase(1'b0);
    res_phase(5, 1'b0);
    bus0.res_valid_i = 1'b1;
    bus0.res_data_i  = 17'h15555;
    #1 chk("pre_rst_en", 32'(bus0.BRAM_en_o), 32'd1);
    rst_n = 1'b0;
    #1 chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    bus0.res_valid_i = 1'b0;
    @(negedge clk);
    start0 = 1'b1;
    read_phase(1'b0);
    res_phase(16, 1'b0);
    repeat (2) @(negedge clk);
    chk("done_count", 32'(done_cnt0), 32'd2);

    // READ_LATENCY=3 instance
    bus1.op_ready_i = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("l3_en", 32'(bus1.BRAM_en_o), 32'd1);
    chk("l3_addr", bus1.BRAM_addr_o, 32'd0);
    for (int m = 0; m < 3; m++) begin
      c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (!bus1.op_valid_o && c < 20);
      chk($sformatf("l3_lat%0d", m), 32'(c), (m == 0) ? 32'd4 : 32'd5);
      chk($sformatf("l3_data%0d", m), 32'(bus1.op_data_o), 32'h1000 + 32'(m));
      chk($sformatf("l3_blk%0d", m), 32'(bus1.op_blk_o), 32'(m));
    end
    bus1.res_valid_i = 1'b1;
    bus1.res_data_i  = 17'h00042;
    c = 0;
    while (!done1 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    chk("l3_done", 32'(done1), 32'd1);
    bus1.res_valid_i = 1'b0;
    @(negedge clk);
    chk("l3_idle", 32'(busy1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
